fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  IF stage with decoupled prefetch: a PC generator issues reads to a synchronous instruction RAM,
//  responses fill a FIFO_DEPTH-entry queue, and the IF/ID register is loaded from the queue head.
//  Adds redirect/flush, ID back-pressure, debug-unit program load, and HALT detection.
//  Sits between the debug unit / hazard unit and the decode stage.
// PARAMETERS
//  NB_BITS     32          data / PC width
//  RAM_DEPTH   10          instruction RAM address bits (byte address); word index = pc[RAM_DEPTH-1:2]
//  FIFO_DEPTH  4           prefetch queue entries; power of 2, >= 2
//  NOP_INSTR   32'h0       instruction injected on bubble/flush (sll $0,$0,0)
//  HALT_OP     6'b111111   opcode (instr[31:26]) that stops fetching
// PORTS
//  i_clk            in   1                   clock, posedge
//  i_rst            in   1                   synchronous, active-high reset
//  i_run            in   1                   1 = fetch enabled; 0 = fetch paused, debug load allowed
//  i_stall          in   1                   ID not accepting; hold IF/ID register
//  i_redirect       in   1                   branch/jump taken: flush queue, restart at i_redirect_addr
//  i_redirect_addr  in   NB_BITS             new fetch PC (word aligned)
//  i_du_we          in   1                   debug-unit RAM write strobe
//  i_du_addr        in   RAM_DEPTH           debug-unit byte address
//  i_du_data        in   NB_BITS             debug-unit write data
//  o_if_id_pc       out  NB_BITS             PC+4 of instruction in IF/ID
//  o_if_id_instr    out  NB_BITS             instruction in IF/ID
//  o_if_id_valid    out  1                   1 = real instruction, 0 = injected NOP
//  o_halt           out  1                   sticky: HALT_OP reached IF/ID
//  o_fifo_count     out  $clog2(FIFO_DEPTH)+1 queue occupancy
// BEHAVIOUR
//  Reset: fetch PC=0, queue empty, in-flight=0, o_if_id_pc=0, o_if_id_instr=NOP_INSTR,
//   o_if_id_valid=0, o_halt=0, o_fifo_count=0. RAM contents retained.
//  Issue: read of fetch PC when i_run & !o_halt & !i_redirect & (count + inflight) < FIFO_DEPTH;
//   fetch PC += 4 on issue; in-flight flag set for one cycle.
//  RAM read latency 1 cycle; the response is pushed as {PC+4, instr} on the following edge.
//  Pipeline: issue at edge E0, push at E1, IF/ID loaded at E2 (3-edge fill latency from empty).
//  IF/ID update when !i_stall: queue non-empty -> pop head, valid=1; empty -> NOP_INSTR, valid=0,
//   pc held. i_stall=1 -> IF/ID and head unchanged; issue continues until the queue is full.
//  Push and pop on the same edge -> count unchanged; never push when full (guaranteed by issue rule).
//  Redirect (priority over stall and issue): at the edge, fetch PC <= i_redirect_addr, queue
//   cleared, in-flight response discarded, IF/ID <= NOP_INSTR with valid=0, o_halt cleared.
//   First read of the new target is issued on the next cycle.
//  HALT: popping an instruction with instr[31:26]==HALT_OP loads it into IF/ID (valid=1) and sets
//   o_halt; issue stops, the in-flight response is discarded, the queue is cleared, and following
//   IF/ID loads are NOP with valid=0. Cleared only by i_rst or i_redirect.
//  Debug load: i_du_we writes RAM[i_du_addr[RAM_DEPTH-1:2]] only when i_run=0; ignored when i_run=1.
//  i_run falling: no new issue; an in-flight response still pushes; the queue drains normally.
//  Priority: i_rst > i_redirect > i_stall > normal.
//  Reset asserted mid-operation: all state returns to reset values at that edge; in-flight read dropped.
//  Width rule: PC arithmetic is mod 2^NB_BITS; the RAM index wraps at 2^(RAM_DEPTH-2) words.
// TESTING
//  1 Load RAM[0..3]={A,B,C,D} via DU with run=0, then run=1 -> IF/ID valid A @E2, then B,C,D,
//    with pc=4,8,12,16.
//  2 i_stall=1 for 6 cycles after A -> IF/ID holds A, count saturates at 4, no lost or duplicated words.
//  3 i_redirect to 0x40 with full queue -> next IF/ID is NOP, valid=0, count=0, then RAM[16] with pc=0x44.
//  4 RAM[2]=HALT -> IF/ID shows HALT then only NOP/valid=0, o_halt=1; redirect to 0 clears o_halt.
//  5 i_du_we while run=1 -> RAM unchanged; the same write with run=0 -> word read back on the next fetch.
//  6 i_rst mid-stream with stall and a read in flight -> all outputs at reset values next cycle;
//    refetch starts at 0.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: IF stage with decoupled prefetch queue, redirect/flush, debug program load and HALT detection
module fetch_prefetch_unit #(
    parameter int               NB_BITS    = 32,
    parameter int               RAM_DEPTH  = 10,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [31:0]      NOP_INSTR  = 32'h0,
    parameter logic [5:0]       HALT_OP    = 6'b111111
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_run,
    input  logic                              i_stall,
    input  logic                              i_redirect,
    input  logic [NB_BITS-1:0]                i_redirect_addr,
    input  logic                              i_du_we,
    input  logic [RAM_DEPTH-1:0]              i_du_addr,
    input  logic [NB_BITS-1:0]                i_du_data,
    output logic [NB_BITS-1:0]                o_if_id_pc,
    output logic [NB_BITS-1:0]                o_if_id_instr,
    output logic                              o_if_id_valid,
    output logic                              o_halt,
    output logic [$clog2(FIFO_DEPTH):0]       o_fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int AW = RAM_DEPTH - 2;

    logic [NB_BITS-1:0] mem [0:2**AW-1];
    logic [NB_BITS-1:0] fifo_pc_q [0:FIFO_DEPTH-1];
    logic [NB_BITS-1:0] fifo_instr_q [0:FIFO_DEPTH-1];
    logic [NB_BITS-1:0] pc_q, pc_d, rd_pc_q, rd_data_q;
    logic [NB_BITS-1:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
    logic [NB_BITS-1:0] head_pc, head_instr;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      du_idx, rd_idx;
    logic               inflight_q, if_valid_q, if_valid_d, halt_q, halt_d;
    logic               issue, push, pop, halt_pop, flush;

    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign head_instr = fifo_instr_q[rd_ptr_q];
    assign du_idx     = AW'(i_du_addr >> 2);
    assign rd_idx     = pc_q[RAM_DEPTH-1:2];

    // issue/push/pop decisions and next-state for PC, queue pointers and IF/ID
    always_comb begin
        issue      = i_run & !halt_q & !i_redirect & ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
        pop        = !i_redirect & !i_stall & (count_q != '0);
        halt_pop   = pop & (head_instr[31:26] == HALT_OP);
        flush      = i_redirect | halt_pop;
        push       = inflight_q & !halt_q & !flush;
        pc_d       = i_redirect ? i_redirect_addr : issue ? pc_q + NB_BITS'(4) : pc_q;
        wr_ptr_d   = flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        if_pc_d    = pop ? head_pc : if_pc_q;
        if_instr_d = pop ? head_instr : (i_redirect | !i_stall) ? NOP_INSTR : if_instr_q;
        if_valid_d = pop | (!i_redirect & i_stall & if_valid_q);
        halt_d     = !i_redirect & (halt_q | halt_pop);
    end

    // control and IF/ID state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q       <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            halt_q     <= halt_d;
        end
    end

    // instruction RAM: debug writes only while paused, synchronous read on issue
    always_ff @(posedge i_clk) begin
        if (i_du_we && !i_run)
            mem[du_idx] <= i_du_data;
        if (issue) begin
            rd_data_q <= mem[rd_idx];
            rd_pc_q   <= pc_q + NB_BITS'(4);
        end
    end

    // prefetch queue storage; occupancy is tracked by the pointers and count above
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= rd_pc_q;
            fifo_instr_q[wr_ptr_q] <= rd_data_q;
        end
    end

    assign o_if_id_pc    = if_pc_q;
    assign o_if_id_instr = if_instr_q;
    assign o_if_id_valid = if_valid_q;
    assign o_halt        = halt_q;
    assign o_fifo_count  = count_q;
endmodule
